upsample_replay: RTL

UPSAMPLE_REPLAY -- requirements
Module: upsample_replay

---
 rtl/upsample_replay_pkg.sv | 13 +
 rtl/upsample_replay_line_ram.sv | 25 ++
 rtl/upsample_replay.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/upsample_replay_pkg.sv
// Shared FSM state encoding and default sizes for the 2x nearest-neighbour upsampler.
// Holds types and constants only; it has no latency or backpressure of its own.
package upsample_replay_pkg;

  typedef enum logic {
    LIVE   = 1'b0,
    REPLAY = 1'b1
  } state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_AWIDTH = 11;

endpackage

// File: rtl/upsample_replay_line_ram.sv
// One-row pixel store: one write port and one synchronous read port, with no reset.
// Read data appears 1 cycle after re and is held until the next re; writes are never stalled.
module line_ram
  import upsample_replay_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [1 << AWIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/upsample_replay.sv
// 2x nearest-neighbour upsampler: each pixel is sent twice and each row twice (the 2nd copy comes from line_ram).
// dout is registered, 1 cycle after din accept, plus one bubble on replay entry; dout_ready low holds every output.
module upsample_replay
  import upsample_replay_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [AWIDTH-1:0] width,
  input  logic [AWIDTH-1:0] height,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_eol,
  output logic              dout_eof,
  output logic [AWIDTH:0]   out_col,
  output logic [AWIDTH:0]   out_row
);

  localparam logic [AWIDTH-1:0] ONE  = AWIDTH'(1);
  localparam logic [AWIDTH-1:0] TWO  = AWIDTH'(2);
  localparam logic [AWIDTH:0]   ONEW = (AWIDTH + 1)'(1);

  state_t            state;
  state_t            state_nxt;
  logic [AWIDTH-1:0] col;
  logic [AWIDTH-1:0] row;
  logic              dup;

  logic              beat;
  logic              adv;
  logic              last_col;
  logic              accept;
  logic              we;
  logic              re;
  logic [AWIDTH-1:0] waddr;
  logic [AWIDTH-1:0] raddr;
  logic [WIDTH-1:0]  rdata;

  assign beat     = clken & dout_valid & dout_ready;
  assign adv      = beat & dup;
  assign last_col = (col == width - ONE);

  // No accept on the final LIVE beat of a row: that pixel belongs to the row after the replay.
  assign din_ready = !rst & clken & (state == LIVE) &
                     (!dout_valid | (dout_ready & dup & !last_col));
  assign accept    = din_valid & din_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state <= LIVE;
    else if (clken) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    we        = accept;
    waddr     = dout_valid ? col + ONE : col;
    re        = 1'b0;
    raddr     = '0;
    case (state)
      LIVE: begin
        if (adv && last_col) begin
          state_nxt = REPLAY;
          re        = 1'b1;
        end
      end
      REPLAY: begin
        if (!dout_valid) begin
          re    = clken;
          raddr = col + ONE;
        end else if (adv) begin
          if (last_col) begin
            state_nxt = LIVE;
          end else begin
            // rdata already holds col+1; keep it one pixel ahead
            re    = 1'b1;
            raddr = col + TWO;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      dup        <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (clken) begin
      if (state == LIVE) begin
        if (beat && !dup) begin
          dup <= 1'b1;
        end else if (adv) begin
          if (last_col) begin
            col        <= '0;
            dup        <= 1'b0;
            dout_valid <= 1'b0;
          end else begin
            col        <= col + ONE;
            dout_valid <= accept;
            if (accept) begin
              dout <= din;
              dup  <= 1'b0;
            end
          end
        end else if (accept) begin
          dout       <= din;
          dout_valid <= 1'b1;
          dup        <= 1'b0;
        end
      end else begin
        if (!dout_valid) begin
          dout       <= rdata;
          dout_valid <= 1'b1;
          dup        <= 1'b0;
        end else if (beat && !dup) begin
          dup <= 1'b1;
        end else if (adv) begin
          if (last_col) begin
            col        <= '0;
            dup        <= 1'b0;
            dout_valid <= 1'b0;
            row        <= (row == height - ONE) ? '0 : row + ONE;
          end else begin
            col  <= col + ONE;
            dout <= rdata;
            dup  <= 1'b0;
          end
        end
      end
    end
  end

  line_ram #(
    .WIDTH  (WIDTH),
    .AWIDTH (AWIDTH)
  ) u_line_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign out_col  = {col, dup};
  assign out_row  = {row, (state == REPLAY)};
  assign dout_eol = dout_valid & (out_col == {width, 1'b0} - ONEW);
  assign dout_eof = dout_eol & (out_row == {height, 1'b0} - ONEW);

endmodule
